// File: rtl/ber_test_engine_if.sv
// Encoder/decoder handshake bundle between the BER engine (master) and the codec under test (slave).
// The engine drives requests and the corrupted codeword; the codec answers with ack/valid strobes.
interface ber_test_engine_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CW_W   = 64
);
  logic              enc_req;
  logic [DATA_W-1:0] enc_data;
  logic              enc_ack;
  logic [CW_W-1:0]   enc_cw;
  logic              dec_start;
  logic [CW_W-1:0]   dec_cw;
  logic              dec_valid;
  logic [DATA_W-1:0] dec_data;
  logic              dec_uncorr;

  modport master (
    output enc_req, enc_data, dec_start, dec_cw,
    input  enc_ack, enc_cw, dec_valid, dec_data, dec_uncorr
  );

  modport slave (
    input  enc_req, enc_data, dec_start, dec_cw,
    output enc_ack, enc_cw, dec_valid, dec_data, dec_uncorr
  );
endinterface

// File: rtl/ber_test_engine.sv
// BER test engine: LFSR words -> encoder -> random single-bit flip -> decoder -> compare, with run stats.
// One vector = encoder wait + decoder wait + 3 cycles; the engine waits on enc_ack/dec_valid (timeout on decode).
module ber_test_engine #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CW_W    = 64,
  parameter int unsigned DEPTH   = 10000,
  parameter int unsigned TIMEOUT = 1024,
  parameter logic [31:0] SEED    = 32'hACE1_2024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [3:0]            ber_lvl_i,
  ber_test_engine_if.master     codec,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           vec_cnt_o,
  output logic [31:0]           err_cnt_o,
  output logic [31:0]           unc_cnt_o,
  output logic [31:0]           to_cnt_o,
  output logic [31:0]           inj_cnt_o,
  output logic [31:0]           cyc_cnt_o
);

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE, S_ENC, S_INJ, S_DEC, S_CMP, S_DONE
  } state_t;

  state_t            state_q;
  logic [31:0]       data_lfsr_q, inj_lfsr_q;
  logic [31:0]       wait_q;
  logic [31:0]       vec_q, err_q, unc_q, to_q, inj_q, cyc_q;
  logic [CW_W-1:0]   cw_q, dec_cw_q;
  logic [DATA_W-1:0] enc_data_q, res_data_q;
  logic              enc_req_q, dec_start_q, busy_q, done_q;
  logic              abort_q, res_unc_q, res_to_q;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0]     data_nxt, inj_nxt, vec_inc;
  logic [3:0]      lvl_c;
  logic [15:0]     thr;
  logic [8:0]      flip_idx;
  logic            inject;
  logic [CW_W-1:0] flip_mask;
  logic            unused_bits;

  assign data_nxt  = lfsr_step(data_lfsr_q);
  assign inj_nxt   = lfsr_step(inj_lfsr_q);
  assign lvl_c     = (ber_lvl_i > 4'd10) ? 4'd10 : ber_lvl_i;
  assign thr       = 16'(lvl_c) * 16'd655;
  // Decision and bit position both come from the freshly advanced injection LFSR.
  assign inject    = inj_nxt[31:16] < thr;
  assign flip_idx  = {1'b0, inj_nxt[7:0]} % 9'(CW_W);
  assign flip_mask = inject ? ({{(CW_W-1){1'b0}}, 1'b1} << flip_idx) : '0;
  assign vec_inc   = sat_inc(vec_q);
  assign unused_bits = ^{inj_nxt, data_nxt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      data_lfsr_q <= SEED;
      inj_lfsr_q  <= SEED;
      wait_q      <= '0;
      vec_q       <= '0;
      err_q       <= '0;
      unc_q       <= '0;
      to_q        <= '0;
      inj_q       <= '0;
      cyc_q       <= '0;
      cw_q        <= '0;
      dec_cw_q    <= '0;
      enc_data_q  <= '0;
      res_data_q  <= '0;
      enc_req_q   <= 1'b0;
      dec_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      res_unc_q   <= 1'b0;
      res_to_q    <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      dec_start_q <= 1'b0;
      if (busy_q) cyc_q <= sat_inc(cyc_q);
      if (busy_q && abort_i) abort_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_ENC;
            busy_q     <= 1'b1;
            enc_req_q  <= 1'b1;
            enc_data_q <= data_lfsr_q[DATA_W-1:0];
            vec_q      <= '0;
            err_q      <= '0;
            unc_q      <= '0;
            to_q       <= '0;
            inj_q      <= '0;
            cyc_q      <= '0;
            abort_q    <= 1'b0;
          end
        end

        S_ENC: begin
          if (codec.enc_ack) begin
            cw_q      <= codec.enc_cw;
            enc_req_q <= 1'b0;
            state_q   <= S_INJ;
          end
        end

        S_INJ: begin
          inj_lfsr_q  <= inj_nxt;
          dec_cw_q    <= cw_q ^ flip_mask;
          if (inject) inj_q <= sat_inc(inj_q);
          dec_start_q <= 1'b1;
          wait_q      <= '0;
          state_q     <= S_DEC;
        end

        S_DEC: begin
          wait_q <= wait_q + 32'd1;
          // A result arriving in the final wait cycle beats the timeout.
          if (codec.dec_valid) begin
            res_data_q <= codec.dec_data;
            res_unc_q  <= codec.dec_uncorr;
            res_to_q   <= 1'b0;
            state_q    <= S_CMP;
          end else if (wait_q == 32'(TIMEOUT - 1)) begin
            res_to_q <= 1'b1;
            to_q     <= sat_inc(to_q);
            state_q  <= S_CMP;
          end
        end

        S_CMP: begin
          if (!res_to_q) begin
            if (res_unc_q)                    unc_q <= sat_inc(unc_q);
            else if (res_data_q != enc_data_q) err_q <= sat_inc(err_q);
          end
          vec_q       <= vec_inc;
          data_lfsr_q <= data_nxt;
          if (vec_inc == 32'(DEPTH) || abort_q || abort_i) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            abort_q <= 1'b0;
          end else begin
            state_q    <= S_ENC;
            enc_req_q  <= 1'b1;
            enc_data_q <= data_nxt[DATA_W-1:0];
          end
        end

        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign codec.enc_req   = enc_req_q;
  assign codec.enc_data  = enc_data_q;
  assign codec.dec_start = dec_start_q;
  assign codec.dec_cw    = dec_cw_q;

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign vec_cnt_o = vec_q;
  assign err_cnt_o = err_q;
  assign unc_cnt_o = unc_q;
  assign to_cnt_o  = to_q;
  assign inj_cnt_o = inj_q;
  assign cyc_cnt_o = cyc_q;

endmodule

// File: tb/tb_ber_test_engine.sv
// Directed bench: three engines (DEPTH 8 / 3 / 1000, TIMEOUT 16) each with a behavioural codec whose
// decoder latency and uncorrectable flag are set per step; expected values are hand-derived or modelled.
module tb_ber_test_engine;

  localparam logic [31:0] SEED = 32'hACE1_2024;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic clk = 1'b0;
  logic rst_n;
  logic start [3];
  logic abort;
  logic [3:0] ber_lvl;
  int   dly [3];
  logic unc_mode [3];

  logic        busy [3];
  logic        done [3];
  logic [31:0] vec_cnt [3], err_cnt [3], unc_cnt [3], to_cnt [3], inj_cnt [3], cyc_cnt [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ber_test_engine_if #(.DATA_W(16), .CW_W(64)) bus ();
    int since = 0;

    // Encoder: zero-latency, data in the low bits; decoder: XOR-folds all four 16-bit lanes.
    assign bus.enc_ack    = bus.enc_req;
    assign bus.enc_cw     = {48'h0, bus.enc_data};
    assign bus.dec_valid  = (dly[g] != 0) && (since == dly[g]);
    assign bus.dec_data   = bus.dec_cw[15:0] ^ bus.dec_cw[31:16] ^ bus.dec_cw[47:32] ^ bus.dec_cw[63:48];
    assign bus.dec_uncorr = unc_mode[g];

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          since <= 0;
      else if (bus.dec_start)              since <= 1;
      else if (since != 0 && since < 4096) since <= since + 1;
    end

    ber_test_engine #(
      .DATA_W (16),
      .CW_W   (64),
      .DEPTH  ((g == 0) ? 8 : (g == 1) ? 3 : 1000),
      .TIMEOUT(16),
      .SEED   (SEED)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start[g]),
      .abort_i  (abort),
      .ber_lvl_i(ber_lvl),
      .codec    (bus.master),
      .busy_o   (busy[g]),
      .done_o   (done[g]),
      .vec_cnt_o(vec_cnt[g]),
      .err_cnt_o(err_cnt[g]),
      .unc_cnt_o(unc_cnt[g]),
      .to_cnt_o (to_cnt[g]),
      .inj_cnt_o(inj_cnt[g]),
      .cyc_cnt_o(cyc_cnt[g])
    );
  end

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ ({32{s[0]}} & POLY);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[g] && n < limit);
  endtask

  initial begin
    int n, k, nstart, pos_bad, cw_bad, m_inj, dones;
    logic [31:0] d, r;
    logic [63:0] cw, hold;
    logic [8:0]  idx;

    rst_n = 1'b0;
    abort = 1'b0;
    ber_lvl = 4'd0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      unc_mode[i] = 1'b0;
    end
    dly[0] = 1; dly[1] = 0; dly[2] = 1;
    hold = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",     busy[0], 0);
    check("rst_done",     done[0], 0);
    check("rst_enc_req",  g_dut[0].bus.enc_req, 0);
    check("rst_dec_start", g_dut[0].bus.dec_start, 0);
    check("rst_enc_data", g_dut[0].bus.enc_data, 0);
    check("rst_dec_cw",   g_dut[0].bus.dec_cw, 0);
    check("rst_vec",      vec_cnt[0], 0);
    check("rst_cyc",      cyc_cnt[0], 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean run, DEPTH=8, 1-cycle decoder: 5 cycles per vector
    pulse_start(0);
    check("s1_busy",    busy[0], 1);
    check("s1_enc_req", g_dut[0].bus.enc_req, 1);
    check("s1_word0",   g_dut[0].bus.enc_data, 16'h2024);
    wait_done(0, 200, n);
    check("s1_done_seen", done[0], 1);
    check("s1_latency",   n, 40);
    check("s1_vec", vec_cnt[0], 8);
    check("s1_err", err_cnt[0], 0);
    check("s1_unc", unc_cnt[0], 0);
    check("s1_to",  to_cnt[0], 0);
    check("s1_inj", inj_cnt[0], 0);
    check("s1_cyc", cyc_cnt[0], 40);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check("s1_done_pulse",    done[0], 0);
    check("s1_start_in_done", busy[0], 0);
    check("s1_hold_vec",      vec_cnt[0], 8);

    // Decoder answers in the exact timeout cycle; results flagged uncorrectable
    dly[0] = 15;
    unc_mode[0] = 1'b1;
    @(negedge clk);
    pulse_start(0);
    wait_done(0, 1000, n);
    check("s2_done_seen", done[0], 1);
    check("s2_latency",   n, 152);
    check("s2_to",  to_cnt[0], 0);
    check("s2_unc", unc_cnt[0], 8);
    check("s2_err", err_cnt[0], 0);
    check("s2_vec", vec_cnt[0], 8);
    check("s2_cyc", cyc_cnt[0], 152);
    dly[0] = 1;
    unc_mode[0] = 1'b0;

    // Silent decoder, DEPTH=3: three 16-cycle timeouts with dec_cw held
    pulse_start(1);
    n = 0; k = 0; nstart = 0; cw_bad = 0;
    while (!done[1] && n < 500) begin
      @(negedge clk);
      n++;
      if (k > 0) begin
        if (g_dut[1].bus.dec_cw !== hold) cw_bad++;
        k--;
      end
      if (g_dut[1].bus.dec_start) begin
        hold = g_dut[1].bus.dec_cw;
        k = 15;
        nstart++;
        if (nstart == 1) check("s3_first_cw", hold, 64'h2024);
      end
    end
    check("s3_done_seen", done[1], 1);
    check("s3_latency",   n, 57);
    check("s3_dec_starts", nstart, 3);
    check("s3_cw_stable", cw_bad, 0);
    check("s3_to",  to_cnt[1], 3);
    check("s3_vec", vec_cnt[1], 3);
    check("s3_err", err_cnt[1], 0);

    // ber_lvl=15 clamps to 10%; flips tracked against a reference LFSR
    ber_lvl = 4'd15;
    d = SEED; r = SEED; m_inj = 0; pos_bad = 0;
    pulse_start(2);
    for (int v = 0; v < 1000; v++) begin
      cw = {48'h0, d[15:0]};
      r = ref_step(r);
      idx = {1'b0, r[7:0]} % 9'd64;
      if (r[31:16] < 16'd6550) begin
        cw[idx] = ~cw[idx];
        m_inj++;
      end
      d = ref_step(d);
      n = 0;
      while (!g_dut[2].bus.dec_start && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (g_dut[2].bus.dec_cw !== cw) pos_bad++;
      @(negedge clk);
    end
    wait_done(2, 100, n);
    check("s4_done_seen", done[2], 1);
    check("s4_vec", vec_cnt[2], 1000);
    check("s4_flip_pos", pos_bad, 0);
    check("s4_inj_model", inj_cnt[2], m_inj);
    check("s4_err_eq_inj", err_cnt[2], inj_cnt[2]);
    check("s4_inj_range", (inj_cnt[2] >= 70 && inj_cnt[2] <= 130), 1);
    check("s4_to",  to_cnt[2], 0);
    check("s4_cyc", cyc_cnt[2], 5000);
    ber_lvl = 4'd0;
    @(negedge clk);

    // Abort during DEC of vector 5, with a stray start while busy
    pulse_start(2);
    n = 0; nstart = 0;
    while (nstart < 5 && n < 200) begin
      @(negedge clk);
      n++;
      if (g_dut[2].bus.dec_start) nstart++;
    end
    check("s5_reach_vec5", nstart, 5);
    abort = 1'b1;
    start[2] = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start[2] = 1'b0;
    check("s5_still_busy", busy[2], 1);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done[2]) dones++;
    end
    check("s5_done_once", dones, 1);
    check("s5_vec",  vec_cnt[2], 5);
    check("s5_idle", busy[2], 0);

    // Reset while the encoder request is up
    pulse_start(0);
    check("s6_enc_req_up", g_dut[0].bus.enc_req, 1);
    rst_n = 1'b0;
    #1;
    check("s6_enc_req_drop", g_dut[0].bus.enc_req, 0);
    check("s6_busy", busy[0], 0);
    check("s6_vec",  vec_cnt[0], 0);
    check("s6_unc",  unc_cnt[0], 0);
    check("s6_cyc",  cyc_cnt[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done[0]) dones++;
    end
    check("s6_no_done",   dones, 0);
    check("s6_stay_idle", busy[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
